// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI transmit frame sequencer.
//   - seq_state_t : sequencer FSM state encoding (IDLE, SEND, HOLD, WAIT, GAP)
//   - width helpers for the byte index, FIFO level, gap counter and TX count
//   - default parameter values and the widths they imply
package spi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_HOLD = 3'd2,
    ST_WAIT = 3'd3,
    ST_GAP  = 3'd4
  } seq_state_t;

  // Byte index width; a single-byte frame still carries a 1-bit index.
  function automatic int idx_width(input int frame_bytes);
    if (frame_bytes > 1) begin
      return $clog2(frame_bytes);
    end else begin
      return 1;
    end
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Gap counter width; GAP_CLKS = 0 still gets a 1-bit (unused) counter.
  function automatic int gap_width(input int gap_clks);
    if (gap_clks > 0) begin
      return $clog2(gap_clks + 1);
    end else begin
      return 1;
    end
  endfunction

  function automatic int count_width(input int frame_bytes);
    return $clog2(frame_bytes + 1);
  endfunction

  localparam int DEF_FRAME_BYTES = 2;
  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_GAP_CLKS    = 8;
  localparam int DEF_MSB_FIRST   = 1;

  localparam int DEF_IDX_W = idx_width(DEF_FRAME_BYTES);
  localparam int DEF_LVL_W = level_width(DEF_FIFO_DEPTH);
  localparam int DEF_GAP_W = gap_width(DEF_GAP_CLKS);
  localparam int DEF_CNT_W = count_width(DEF_FRAME_BYTES);

endpackage

// File: rtl/spi_tx_frame_sequencer_fifo.sv
// sync_fifo: single-clock frame FIFO with first-word-fall-through read data.
// Ports:
//   i_Clk, i_Rst_L : clock, asynchronous active-low reset
//   push, wr_data  : write request and data (ignored while full)
//   pop            : read request; rd_data shows the head entry (ignored while empty)
//   full, empty    : occupancy flags, decoded from the registered level
//   level          : number of stored entries
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_L,
  input  logic                         push,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             rd_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [LVL_W-1:0] count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full      = (count_r == LVL_W'(DEPTH));
  assign empty     = (count_r == LVL_W'(0));
  assign level     = count_r;
  assign rd_data   = mem_r[rd_ptr_r];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {LVL_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + LVL_W'(1);
        2'b01:   count_r <= count_r - LVL_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_frame_sequencer.sv
// spi_tx_frame_sequencer: buffers multi-byte frames and feeds them one byte at a
// time to an SPI master's TX_Byte/TX_DV/TX_Ready handshake.
// Ports:
//   i_Clk, i_Rst_L            : clock, asynchronous active-low reset
//   i_Frame, i_Frame_DV       : frame write port
//   o_Frame_Ready             : FIFO not full
//   o_Fifo_Level, o_Overflow  : stored frames, sticky dropped-write flag
//   i_Mode, i_Trigger         : 1 = streaming, 0 = single-shot armed by i_Trigger edges
//   o_TX_Byte, o_TX_DV        : byte and one-cycle strobe to the SPI master
//   i_TX_Ready                : SPI master ready for a byte
//   o_TX_Count                : constant FRAME_BYTES (bytes per CS-low burst)
//   o_Busy                    : sequencer is not idle
module spi_tx_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int GAP_CLKS    = DEF_GAP_CLKS,
  parameter int MSB_FIRST   = DEF_MSB_FIRST
) (
  input  logic                                i_Clk,
  input  logic                                i_Rst_L,
  input  logic [8*FRAME_BYTES-1:0]            i_Frame,
  input  logic                                i_Frame_DV,
  output logic                                o_Frame_Ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     o_Fifo_Level,
  output logic                                o_Overflow,
  input  logic                                i_Mode,
  input  logic                                i_Trigger,
  output logic [7:0]                          o_TX_Byte,
  output logic                                o_TX_DV,
  input  logic                                i_TX_Ready,
  output logic [$clog2(FRAME_BYTES+1)-1:0]    o_TX_Count,
  output logic                                o_Busy
);

  localparam int FW    = 8 * FRAME_BYTES;
  localparam int IDX_W = idx_width(FRAME_BYTES);
  localparam int LVL_W = level_width(FIFO_DEPTH);
  localparam int GAP_W = gap_width(GAP_CLKS);
  localparam int CNT_W = count_width(FRAME_BYTES);

  seq_state_t       state_r;
  seq_state_t       state_nxt_s;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] idx_nxt_s;
  logic [GAP_W-1:0] gap_r;
  logic [GAP_W-1:0] gap_nxt_s;
  logic [FW-1:0]    frame_r;
  logic [FW-1:0]    frame_nxt_s;
  logic [7:0]       tx_byte_r;
  logic [7:0]       tx_byte_nxt_s;
  logic             tx_dv_r;
  logic             tx_dv_nxt_s;
  logic [7:0]       cur_byte_s;
  logic             pop_s;
  logic             push_s;
  logic             trig_q_r;
  logic             trig_rise_s;
  logic             arm_r;
  logic             arm_nxt_s;
  logic             overflow_r;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic [LVL_W-1:0] fifo_level_s;
  logic [FW-1:0]    fifo_rd_data_s;

  assign push_s        = i_Frame_DV & ~fifo_full_s;
  assign trig_rise_s   = i_Trigger & ~trig_q_r;
  assign o_Frame_Ready = ~fifo_full_s;
  assign o_Fifo_Level  = fifo_level_s;
  assign o_Overflow    = overflow_r;
  assign o_TX_Byte     = tx_byte_r;
  assign o_TX_DV       = tx_dv_r;
  assign o_TX_Count    = CNT_W'(FRAME_BYTES);
  assign o_Busy        = (state_r != ST_IDLE);

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .push    (push_s),
    .wr_data (i_Frame),
    .pop     (pop_s),
    .rd_data (fifo_rd_data_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .level   (fifo_level_s)
  );

  // Select the byte addressed by the index; MSB_FIRST walks from the top byte down.
  always_comb begin
    if (MSB_FIRST != 0) begin
      cur_byte_s = 8'(frame_r >> (8 * (FRAME_BYTES - 1 - int'(idx_r))));
    end else begin
      cur_byte_s = 8'(frame_r >> (8 * int'(idx_r)));
    end
  end

  // Next-state and datapath decisions of the sequencer FSM.
  always_comb begin
    state_nxt_s   = state_r;
    idx_nxt_s     = idx_r;
    gap_nxt_s     = gap_r;
    frame_nxt_s   = frame_r;
    tx_byte_nxt_s = tx_byte_r;
    tx_dv_nxt_s   = 1'b0;
    pop_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // i_Mode is only looked at here, so a mode change lands between frames.
        if (!fifo_empty_s && (i_Mode || arm_r)) begin
          pop_s       = 1'b1;
          frame_nxt_s = fifo_rd_data_s;
          idx_nxt_s   = {IDX_W{1'b0}};
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (i_TX_Ready) begin
          tx_dv_nxt_s   = 1'b1;
          tx_byte_nxt_s = cur_byte_s;
          state_nxt_s   = ST_HOLD;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_HOLD: begin
        // The master drops ready one cycle after the strobe; skip that stale cycle.
        state_nxt_s = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_TX_Ready) begin
          if (idx_r < IDX_W'(FRAME_BYTES - 1)) begin
            idx_nxt_s   = idx_r + IDX_W'(1);
            state_nxt_s = ST_SEND;
          end else if (GAP_CLKS > 0) begin
            gap_nxt_s   = GAP_W'(GAP_CLKS);
            state_nxt_s = ST_GAP;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_r <= GAP_W'(1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s   = gap_r - GAP_W'(1);
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and registered transmit outputs.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r   <= ST_IDLE;
      idx_r     <= {IDX_W{1'b0}};
      gap_r     <= {GAP_W{1'b0}};
      frame_r   <= {FW{1'b0}};
      tx_byte_r <= 8'h00;
      tx_dv_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      idx_r     <= idx_nxt_s;
      gap_r     <= gap_nxt_s;
      frame_r   <= frame_nxt_s;
      tx_byte_r <= tx_byte_nxt_s;
      tx_dv_r   <= tx_dv_nxt_s;
    end
  end

  // Arm flag: a fresh trigger edge wins over the clear from a pop in the same cycle.
  always_comb begin
    if (i_Mode) begin
      arm_nxt_s = 1'b0;
    end else if (trig_rise_s) begin
      arm_nxt_s = 1'b1;
    end else if (pop_s) begin
      arm_nxt_s = 1'b0;
    end else begin
      arm_nxt_s = arm_r;
    end
  end

  // Trigger edge history, arm flag and sticky overflow.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      trig_q_r   <= 1'b0;
      arm_r      <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      trig_q_r <= i_Trigger;
      arm_r    <= arm_nxt_s;
      if (i_Frame_DV && fifo_full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

endmodule
